pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer for the single-cycle MIPS datapath.

---
 rtl/pc_fetch_unit_pkg.sv | 20 ++
 rtl/pc_fetch_unit_target_calc.sv | 17 +
 rtl/pc_fetch_unit.sv | 131 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared state encoding, PC step and default vectors for the fetch unit.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_EXEC = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0080;

  // Word-scaled, sign-extended branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_target_calc.sv
// rtl/pc_fetch_unit_target_calc.sv - combinational next-PC candidates (sequential, branch, jump).
module pc_fetch_unit_target_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_jtarget,
  output logic [31:0] o_pc_inc,
  output logic [31:0] o_pc_equal,
  output logic [31:0] o_pc_jump
);

  assign o_pc_inc   = i_pc + PC_STEP;
  assign o_pc_equal = o_pc_inc + branch_offset(i_imm16);
  assign o_pc_jump  = {o_pc_inc[31:28], i_jtarget, 2'b00};

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and req/ack fetch sequencer; PC_ALIGN_CHECK_EN adds
// misaligned-next_pc trapping and the o_align_err pulse.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_next_pc,
  input  logic        i_stall,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_jtarget,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_inc,
  output logic [31:0] o_pc_equal,
`ifdef PC_ALIGN_CHECK_EN
  output logic        o_align_err,
`endif
  output logic [31:0] o_pc_jump
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_instr_valid;
  logic         w_capture;
  logic         w_pc_load;
  logic         w_imem_req;
  logic [31:0]  w_pc_nxt;

`ifdef PC_ALIGN_CHECK_EN
  logic r_align_err;
  logic w_misaligned;

  assign w_misaligned = (i_next_pc[1:0] != 2'b00);
  assign w_pc_nxt     = w_misaligned ? TRAP_VEC : {i_next_pc[31:2], 2'b00};
  assign o_align_err  = r_align_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= w_pc_load & w_misaligned;
    end
  end
`else
  logic w_unused_align;

  // Low next_pc bits are dropped, so the trap vector has no role in this build.
  assign w_unused_align = ^{i_next_pc[1:0], TRAP_VEC};
  assign w_pc_nxt       = {i_next_pc[31:2], 2'b00};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_pc_load   = 1'b0;
    w_imem_req  = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_REQ;
      ST_REQ: begin
        w_imem_req = 1'b1;
        if (i_imem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_imem_req = 1'b1;
        if (i_imem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!i_stall) begin
          w_pc_load   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0000_0000;
      r_instr_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_instr       <= i_imem_rdata;
        r_instr_valid <= 1'b1;
      end
      if (w_pc_load) begin
        r_pc          <= w_pc_nxt;
        r_instr_valid <= 1'b0;
      end
    end
  end

  // Request is decoded from state so reset drops it without waiting for a clock.
  assign o_imem_req    = w_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;

  pc_fetch_unit_target_calc u_target_calc (
    .i_pc       (r_pc),
    .i_imm16    (i_imm16),
    .i_jtarget  (i_jtarget),
    .o_pc_inc   (o_pc_inc),
    .o_pc_equal (o_pc_equal),
    .o_pc_jump  (o_pc_jump)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit (default and PC_ALIGN_CHECK_EN builds).
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        stall;
  logic [15:0] imm16;
  logic [25:0] jtarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] pc_equal;
  logic [31:0] pc_jump;
  logic        align_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_next_pc    (next_pc),
    .i_stall      (stall),
    .i_imm16      (imm16),
    .i_jtarget    (jtarget),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .o_instr      (instr),
    .o_instr_valid(instr_valid),
    .o_pc         (pc),
    .o_pc_inc     (pc_inc),
    .o_pc_equal   (pc_equal),
`ifdef PC_ALIGN_CHECK_EN
    .o_align_err  (align_err),
`endif
    .o_pc_jump    (pc_jump)
  );

`ifndef PC_ALIGN_CHECK_EN
  assign align_err = 1'b0;
`endif

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Transaction-level model: a fetch is pending, an instruction is held, or we are booting.
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_fetch, m_booted, m_align;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_instr <= 32'h0; m_valid <= 1'b0;
      m_fetch <= 1'b0; m_booted <= 1'b0; m_align <= 1'b0;
    end else begin
      m_align <= 1'b0;
      if (!m_booted) begin
        m_booted <= 1'b1;
        m_fetch  <= 1'b1;
      end else if (m_fetch) begin
        if (imem_ack) begin
          m_instr <= imem_rdata;
          m_valid <= 1'b1;
          m_fetch <= 1'b0;
        end
      end else if (m_valid && !stall) begin
        m_valid <= 1'b0;
        m_fetch <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        if (next_pc % 4 != 0) begin
          m_pc    <= 32'h0000_0080;
          m_align <= 1'b1;
        end else begin
          m_pc <= next_pc;
        end
`else
        m_pc <= next_pc - (next_pc % 4);
`endif
      end
    end
  end

  function automatic logic [31:0] exp_equal(input logic [31:0] p, input logic [15:0] imm);
    int off;
    off = int'($signed(imm));
    return p + 32'd4 + 32'(off * 4);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk1 ("m_req",      imem_req,    m_fetch);
      chk32("m_addr",     imem_addr,   m_pc);
      chk32("m_pc",       pc,          m_pc);
      chk1 ("m_valid",    instr_valid, m_valid);
      chk32("m_instr",    instr,       m_instr);
      chk32("m_pc_inc",   pc_inc,      m_pc + 32'd4);
      chk32("m_pc_equal", pc_equal,    exp_equal(m_pc, imm16));
      chk32("m_pc_jump",  pc_jump,     ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jtarget) * 32'd4));
      chk1 ("m_align",    align_err,   m_align);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] v_pc  [3] = '{32'h1234_5678, 32'h8000_0000, 32'h7FFF_FFF0};
  logic [15:0] v_imm [3] = '{16'h0010, 16'h8000, 16'h7FFF};
  logic [25:0] v_jt  [3] = '{26'h3FF_FFFF, 26'h000_0001, 26'h155_5555};
  int          v_dly [3] = '{0, 2, 1};

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b1; next_pc = 32'h0;
    imm16 = 16'h0; jtarget = 26'h0; imem_rdata = 32'h0;
    repeat (2) tick();
    chk1 ("rst_req",   imem_req,    1'b0);
    chk32("rst_pc",    pc,          32'h0);
    chk1 ("rst_valid", instr_valid, 1'b0);
    chk32("rst_instr", instr,       32'h0);

    imem_ack = 1'b1; imem_rdata = 32'h2008_0005; rst_n = 1'b1;
    tick();
    chk1 ("s1_req",   imem_req,  1'b1);
    chk32("s1_addr",  imem_addr, 32'h0);
    tick();
    chk32("s1_instr", instr,       32'h2008_0005);
    chk1 ("s1_valid", instr_valid, 1'b1);
    chk1 ("s1_req_lo", imem_req,   1'b0);

    next_pc = 32'h40; imem_ack = 1'b0;
    repeat (5) begin
      tick();
      chk32("s3_pc_hold", pc, 32'h0);
      chk1 ("s3_valid_hold", instr_valid, 1'b1);
    end
    stall = 1'b0;
    tick();
    stall = 1'b1;
    chk32("s3_pc",   pc,          32'h40);
    chk1 ("s3_valid", instr_valid, 1'b0);

    for (int i = 0; i < 3; i++) begin
      chk1 ("s2_req",  imem_req,  1'b1);
      chk32("s2_addr", imem_addr, 32'h40);
      tick();
    end
    chk1 ("s2_req4",  imem_req,  1'b1);
    chk32("s2_addr4", imem_addr, 32'h40);
    imem_ack = 1'b1; imem_rdata = 32'hACE0_1234;
    tick();
    chk1 ("s2_req_lo", imem_req,   1'b0);
    chk32("s2_instr",  instr,      32'hACE0_1234);
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk32("s2_single", instr, 32'hACE0_1234);

    next_pc = 32'h100; stall = 1'b0;
    tick();
    stall = 1'b1; imm16 = 16'hFFFF; jtarget = 26'h000_0010;
    #1;
    chk32("s4_pc",    pc,       32'h100);
    chk32("s4_inc",   pc_inc,   32'h104);
    chk32("s4_equal", pc_equal, 32'h100);
    chk32("s4_jump",  pc_jump,  32'h40);
    tick();

    next_pc = 32'h102; stall = 1'b0;
    tick();
    stall = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
    chk32("s6_pc",    pc,        32'h80);
    chk1 ("s6_align", align_err, 1'b1);
    tick();
    chk1 ("s6_align_lo", align_err, 1'b0);
`else
    chk32("s6_pc", pc, 32'h100);
    tick();
`endif

    next_pc = 32'hFFFF_FFFC; stall = 1'b0; imem_ack = 1'b0;
    tick();
    stall = 1'b1;
    chk32("s5_pc",    pc,       32'hFFFF_FFFC);
    chk32("s5_inc",   pc_inc,   32'h0);
    chk32("s5_equal", pc_equal, 32'hFFFF_FFFC);
    chk32("s5_jump",  pc_jump,  32'h40);
    tick();
    chk1 ("s5_wait_req", imem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1 ("s5_rst_req",   imem_req,    1'b0);
    chk32("s5_rst_pc",    pc,          32'h0);
    chk1 ("s5_rst_valid", instr_valid, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    tick();
    chk1 ("s5_late_ack_req",   imem_req, 1'b0);
    chk32("s5_late_ack_instr", instr,    32'h0);
    rst_n = 1'b1;
    tick();
    chk1 ("s5_boot_req",  imem_req,  1'b1);
    chk32("s5_boot_addr", imem_addr, 32'h0);
    tick();
    chk32("s5_boot_instr", instr, 32'h1111_2222);

    for (int i = 0; i < 3; i++) begin
      next_pc = v_pc[i]; imm16 = v_imm[i]; jtarget = v_jt[i];
      imem_ack = 1'b0; stall = 1'b0; imem_rdata = 32'hC0DE_0000 + 32'(i);
      tick();
      stall = 1'b1;
      chk32("vec_pc", pc, v_pc[i]);
      repeat (v_dly[i]) tick();
      imem_ack = 1'b1;
      tick();
      chk1 ("vec_valid", instr_valid, 1'b1);
      chk32("vec_instr", instr, 32'hC0DE_0000 + 32'(i));
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
